// File: rtl/fgseq_pkg.sv
// Shared types and field widths for the function-generator sequencer.
package fgseq_pkg;

   localparam int unsigned WaveW     = 3;
   localparam int unsigned AmpW      = 2;
   localparam int unsigned FreqW     = 5;
   localparam int unsigned DwellWDef = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StDwell = 2'd2
   } state_e;

   typedef struct packed {
      logic [WaveW-1:0] wave;
      logic [AmpW-1:0]  amp;
      logic [FreqW-1:0] freq;
   } setting_t;

   typedef struct packed {
      setting_t               set;
      logic [DwellWDef-1:0]   dwell;
   } entry_t;

endpackage

// File: rtl/fgseq_dwell_timer.sv
// Loadable down-counter; expire_o flags the last enabled cycle (count == 1).
module fgseq_dwell_timer #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [Width-1:0] value_i,
   output logic             expire_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/fg_seq_ctrl.sv
// Table-driven sequencer for the function generator; define FGSEQ_LOOP_EN to add
// the loop input that restarts at entry 0 instead of finishing.
module fg_seq_ctrl
   import fgseq_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DWELL_W = 16,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
`ifdef FGSEQ_LOOP_EN
   input  logic               loop,
`endif
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [WaveW-1:0]   wr_wave,
   input  logic [AmpW-1:0]    wr_amp,
   input  logic [FreqW-1:0]   wr_freq,
   input  logic [DWELL_W-1:0] wr_dwell,
   input  logic [AW-1:0]      last_idx,
   output logic [WaveW-1:0]   wave_sel,
   output logic [AmpW-1:0]    amp_sel,
   output logic [FreqW-1:0]   cnt_load,
   output logic               ld,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      cur_idx
);

   setting_t           tbl_q   [DEPTH];
   logic [DWELL_W-1:0] dwell_q [DEPTH];

   state_e        state_q, state_d;
   setting_t      out_q;
   logic [AW-1:0] cur_idx_q, next_idx;
   logic          done_q, done_d;
   logic          go_load, expire, final_entry;
   logic [DWELL_W-1:0] dwell_val;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl_q[i]   <= '0;
            dwell_q[i] <= '0;
         end
      end else if (wr_en) begin
         tbl_q[wr_addr]   <= '{wave: wr_wave, amp: wr_amp, freq: wr_freq};
         dwell_q[wr_addr] <= wr_dwell;
      end
   end

   // last_idx below the current index also ends the pass, so idx never runs off the table.
   assign final_entry = (cur_idx_q >= last_idx);

   always_comb begin
      state_d  = state_q;
      go_load  = 1'b0;
      next_idx = cur_idx_q;
      done_d   = 1'b0;
      if (stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  go_load  = 1'b1;
                  next_idx = '0;
               end
            end
            StLoad: state_d = StDwell;
            StDwell: begin
               if (expire) begin
                  if (!final_entry) begin
                     go_load  = 1'b1;
                     next_idx = cur_idx_q + AW'(1);
`ifdef FGSEQ_LOOP_EN
                  end else if (loop) begin
                     go_load  = 1'b1;
                     next_idx = '0;
`endif
                  end else begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
         if (go_load) state_d = StLoad;
      end
   end

   // Settings are captured on entry to LOAD so they are valid in the same cycle as ld.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         out_q     <= '0;
         cur_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (go_load) begin
            out_q     <= tbl_q[next_idx];
            cur_idx_q <= next_idx;
         end
      end
   end

   assign dwell_val = (dwell_q[next_idx] == '0) ? DWELL_W'(1) : dwell_q[next_idx];

   fgseq_dwell_timer #(
      .Width (DWELL_W)
   ) u_timer (
      .clk_i    (clk),
      .rst_ni   (rst),
      .load_i   (go_load),
      .en_i     (state_q == StDwell),
      .value_i  (dwell_val),
      .expire_o (expire)
   );

   assign wave_sel = out_q.wave;
   assign amp_sel  = out_q.amp;
   assign cnt_load = out_q.freq;
   assign cur_idx  = cur_idx_q;
   assign ld       = (state_q == StLoad);
   assign busy     = (state_q != StIdle);
   assign done     = done_q;

endmodule

// File: tb/tb_fg_seq_ctrl.sv
// Directed bench for fg_seq_ctrl; loop checks run only when FGSEQ_LOOP_EN is defined.
module tb_fg_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, stop, wr_en;
   logic [2:0]  wr_addr, wr_wave, last_idx;
   logic [1:0]  wr_amp;
   logic [4:0]  wr_freq;
   logic [15:0] wr_dwell;
   logic [2:0]  wave_sel, cur_idx;
   logic [1:0]  amp_sel;
   logic [4:0]  cnt_load;
   logic        ld, busy, done;
`ifdef FGSEQ_LOOP_EN
   logic        loop;
`endif

   int total = 0;
   int bad   = 0;
   int m_wave [8];
   int m_amp  [8];
   int m_freq [8];
   int exp_idx [8];

   always #5 clk = ~clk;

   fg_seq_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
`ifdef FGSEQ_LOOP_EN
      .loop     (loop),
`endif
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_wave  (wr_wave),
      .wr_amp   (wr_amp),
      .wr_freq  (wr_freq),
      .wr_dwell (wr_dwell),
      .last_idx (last_idx),
      .wave_sel (wave_sel),
      .amp_sel  (amp_sel),
      .cnt_load (cnt_load),
      .ld       (ld),
      .busy     (busy),
      .done     (done),
      .cur_idx  (cur_idx)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wr(input int a, input int w, input int am, input int f, input int d);
      wr_en    = 1'b1;
      wr_addr  = 3'(a);
      wr_wave  = 3'(w);
      wr_amp   = 2'(am);
      wr_freq  = 5'(f);
      wr_dwell = 16'(d);
      m_wave[a] = w;
      m_amp[a]  = am;
      m_freq[a] = f;
      step();
      wr_en = 1'b0;
   endtask

   // Pulse (or hold) start, then check ld/done/busy on cycles 1..n against bit masks.
   task automatic run_seq(input string tag, input int n, input logic [15:0] ldm,
                          input logic [15:0] dnm, input logic [15:0] bsm, input bit hold);
      int k = 0;
      start = 1'b1;
      for (int c = 1; c <= n; c++) begin
         step();
         if (!hold && c == 1) start = 1'b0;
         chk({tag, "_ld"},   32'(ld),   32'(ldm[c]));
         chk({tag, "_done"}, 32'(done), 32'(dnm[c]));
         chk({tag, "_busy"}, 32'(busy), 32'(bsm[c]));
         if (ldm[c]) begin
            chk({tag, "_idx"},  32'(cur_idx),  32'(exp_idx[k]));
            chk({tag, "_wave"}, 32'(wave_sel), 32'(m_wave[exp_idx[k]]));
            chk({tag, "_amp"},  32'(amp_sel),  32'(m_amp[exp_idx[k]]));
            chk({tag, "_freq"}, 32'(cnt_load), 32'(m_freq[exp_idx[k]]));
            k++;
         end
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_wave = '0; wr_amp = '0; wr_freq = '0; wr_dwell = '0;
      last_idx = '0;
`ifdef FGSEQ_LOOP_EN
      loop = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         m_wave[i] = 0; m_amp[i] = 0; m_freq[i] = 0; exp_idx[i] = 0;
      end
      step(); step();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ld",   32'(ld),   0);
      chk("rst_wave", 32'(wave_sel), 0);
      chk("rst_idx",  32'(cur_idx),  0);
      rst = 1'b1;
      step();

      wr(0, 1, 0, 5, 3);
      wr(1, 3, 1, 10, 2);
      wr(2, 5, 2, 31, 1);
      last_idx = 3'd2;
      exp_idx = '{0, 1, 2, 0, 0, 0, 0, 0};
      run_seq("pass", 11, 16'h0122, 16'h0400, 16'h03FE, 1'b0);

      // Zero dwell behaves as one cycle.
      wr(0, 1, 0, 5, 0);
      last_idx = 3'd0;
      run_seq("dw0", 4, 16'h0002, 16'h0008, 16'h0006, 1'b0);
      wr(0, 1, 0, 5, 3);
      last_idx = 3'd2;

      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      chk("stop_ld",   32'(ld),   0);
      chk("stop_done", 32'(done), 0);
      chk("stop_wave", 32'(wave_sel), 3);
      chk("stop_amp",  32'(amp_sel),  1);
      chk("stop_freq", 32'(cnt_load), 10);
      chk("stop_idx",  32'(cur_idx),  1);
      step(); step();
      chk("stop_nodone", 32'(done), 0);
      start = 1'b1;
      stop  = 1'b1;
      step();
      chk("ss_busy", 32'(busy), 0);
      chk("ss_ld",   32'(ld),   0);
      start = 1'b0;
      stop  = 1'b0;
      step();

      // Rewrite the active entry mid-dwell; outputs must not change until its next LOAD.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      wr(1, 4, 1, 10, 2);
      chk("live_wave", 32'(wave_sel), 3);
      step();
      chk("live_next", 32'(wave_sel), 5);
      step(); step();
      chk("live_done", 32'(done), 1);
      step();

      exp_idx = '{0, 1, 2, 0, 0, 0, 0, 0};
      run_seq("hold", 11, 16'h0922, 16'h0400, 16'h0BFE, 1'b1);
      start = 1'b0;
      stop  = 1'b1;
      step();
      stop = 1'b0;
      chk("hold_stop", 32'(busy), 0);
      step();

      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      rst = 1'b0;
      step(); step();
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ld",   32'(ld),   0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_wave", 32'(wave_sel), 0);
      chk("mrst_amp",  32'(amp_sel),  0);
      chk("mrst_freq", 32'(cnt_load), 0);
      chk("mrst_idx",  32'(cur_idx),  0);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_wave[i] = 0; m_amp[i] = 0; m_freq[i] = 0;
      end
      step();
      run_seq("clr", 8, 16'h002A, 16'h0080, 16'h007E, 1'b0);
      step();

`ifdef FGSEQ_LOOP_EN
      wr(0, 2, 3, 7, 2);
      wr(1, 4, 2, 9, 2);
      last_idx = 3'd1;
      loop = 1'b1;
      exp_idx = '{0, 1, 0, 1, 0, 0, 0, 0};
      run_seq("loop", 12, 16'h0492, 16'h0000, 16'h1FFE, 1'b0);
      loop = 1'b0;
      step();
      chk("loop_done", 32'(done), 1);
      chk("loop_busy", 32'(busy), 0);
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
